// File: rtl/ov7670_config_seq.sv
// OV7670 configuration sequencer: walks the register ROM, decodes data/delay/end
// entries and issues {register, value} writes to the SCCB master over valid/ready.
module ov7670_config_seq #(
    parameter int unsigned DELAY_CYCLES = 250_000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    output logic [7:0]  rom_addr,
    input  logic [15:0] rom_data,
    output logic        sccb_valid,
    output logic [7:0]  sccb_reg,
    output logic [7:0]  sccb_data,
    input  logic        sccb_ready,
    output logic        busy,
    output logic        done
);

    localparam int unsigned CNT_W = (DELAY_CYCLES > 1) ? $clog2(DELAY_CYCLES) : 1;
    localparam logic [CNT_W-1:0] DELAY_LOAD = CNT_W'(DELAY_CYCLES - 1);
    localparam logic [15:0] ENTRY_END   = 16'hFFFF;
    localparam logic [15:0] ENTRY_DELAY = 16'hFFF0;
    localparam logic [7:0]  LAST_ADDR   = 8'hFF;

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_DECODE,
        S_SEND,
        S_DELAY,
        S_DONE
    } state_t;

    state_t           state, state_next;
    logic [7:0]       addr_next;
    logic             valid_next;
    logic [7:0]       reg_next;
    logic [7:0]       data_next;
    logic [CNT_W-1:0] cnt, cnt_next;
    logic             busy_next;
    logic             done_next;

    // State and registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= S_IDLE;
            rom_addr   <= 8'd0;
            sccb_valid <= 1'b0;
            sccb_reg   <= 8'd0;
            sccb_data  <= 8'd0;
            cnt        <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
        end else begin
            state      <= state_next;
            rom_addr   <= addr_next;
            sccb_valid <= valid_next;
            sccb_reg   <= reg_next;
            sccb_data  <= data_next;
            cnt        <= cnt_next;
            busy       <= busy_next;
            done       <= done_next;
        end
    end

    // Next-state and next-output logic
    always_comb begin
        state_next = state;
        addr_next  = rom_addr;
        valid_next = sccb_valid;
        reg_next   = sccb_reg;
        data_next  = sccb_data;
        cnt_next   = cnt;

        unique case (state)
            S_IDLE, S_DONE: begin
                if (start) begin
                    addr_next  = 8'd0;
                    state_next = S_FETCH;
                end
            end
            S_FETCH: begin
                state_next = S_DECODE;
            end
            S_DECODE: begin
                if (rom_data == ENTRY_END) begin
                    state_next = S_DONE;
                end else if (rom_data == ENTRY_DELAY) begin
                    cnt_next   = DELAY_LOAD;
                    state_next = S_DELAY;
                end else begin
                    reg_next   = rom_data[15:8];
                    data_next  = rom_data[7:0];
                    valid_next = 1'b1;
                    state_next = S_SEND;
                end
            end
            S_SEND: begin
                if (sccb_ready) begin
                    valid_next = 1'b0;
                    if (rom_addr != LAST_ADDR) begin
                        addr_next  = rom_addr + 8'd1;
                        state_next = S_FETCH;
                    end else begin
                        state_next = S_DONE;
                    end
                end
            end
            S_DELAY: begin
                if (cnt == '0) begin
                    if (rom_addr != LAST_ADDR) begin
                        addr_next  = rom_addr + 8'd1;
                        state_next = S_FETCH;
                    end else begin
                        state_next = S_DONE;
                    end
                end else begin
                    cnt_next = cnt - CNT_W'(1);
                end
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase

        busy_next = (state_next != S_IDLE) && (state_next != S_DONE);
        done_next = (state_next == S_DONE);
    end

endmodule

// File: tb/tb_ov7670_config_seq.sv
// Directed self-checking bench for ov7670_config_seq with a registered-ROM model
// and DELAY_CYCLES = 8.
module tb_ov7670_config_seq;

    localparam int unsigned DLY = 8;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [7:0]  rom_addr;
    logic [15:0] rom_data;
    logic        sccb_valid;
    logic [7:0]  sccb_reg;
    logic [7:0]  sccb_data;
    logic        sccb_ready;
    logic        busy;
    logic        done;

    logic [15:0] mem [256];
    logic [7:0]  xr_q [$];
    logic [7:0]  xd_q [$];
    int          xc_q [$];
    int          cyc;
    int          checks;
    int          errors;
    logic        hold;
    logic [7:0]  hold_r;
    logic [7:0]  hold_d;

    ov7670_config_seq #(.DELAY_CYCLES(DLY)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .rom_addr   (rom_addr),
        .rom_data   (rom_data),
        .sccb_valid (sccb_valid),
        .sccb_reg   (sccb_reg),
        .sccb_data  (sccb_data),
        .sccb_ready (sccb_ready),
        .busy       (busy),
        .done       (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Registered ROM: entry appears one clock after the address is sampled
    always @(posedge clk) rom_data <= mem[rom_addr];

    // Cycle stamp and transfer log
    initial cyc = 0;
    always @(posedge clk) begin
        cyc = cyc + 1;
        if (rst_n && sccb_valid && sccb_ready) begin
            xr_q.push_back(sccb_reg);
            xd_q.push_back(sccb_data);
            xc_q.push_back(cyc);
        end
    end

    // A stalled request must persist unchanged into the next cycle
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hold = 1'b0;
        end else begin
            if (hold) begin
                checks = checks + 1;
                assert (sccb_valid === 1'b1 && sccb_reg === hold_r && sccb_data === hold_d)
                else begin
                    errors = errors + 1;
                    $error("FAIL hold_stable: observed v=%0b %0h/%0h expected v=1 %0h/%0h",
                           sccb_valid, sccb_reg, sccb_data, hold_r, hold_d);
                end
            end
            hold   = sccb_valid && !sccb_ready;
            hold_r = sccb_reg;
            hold_d = sccb_data;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks = checks + 1;
        assert (obs === exp)
        else begin
            errors = errors + 1;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic wait_done(input int bound);
        int n;
        n = 0;
        while (done !== 1'b1 && n < bound) begin
            tick();
            n++;
        end
        check("done_reached", 32'(done), 32'd1);
    endtask

    task automatic wait_valid(input int bound);
        int n;
        n = 0;
        while (sccb_valid !== 1'b1 && n < bound) begin
            tick();
            n++;
        end
        check("valid_reached", 32'(sccb_valid), 32'd1);
    endtask

    task automatic clear_log();
        xr_q.delete();
        xd_q.delete();
        xc_q.delete();
    endtask

    task automatic load_basic();
        for (int i = 0; i < 256; i++) mem[i] = 16'hFFFF;
        mem[0] = 16'h1280;
        mem[1] = 16'hFFF0;
        mem[2] = 16'h1214;
        mem[3] = 16'hFFFF;
    endtask

    function automatic logic [31:0] outs();
        return 32'({rom_addr, sccb_valid, sccb_reg, sccb_data, busy, done});
    endfunction

    initial begin
        int c0;
        int dcyc;
        checks     = 0;
        errors     = 0;
        rst_n      = 1'b0;
        start      = 1'b0;
        sccb_ready = 1'b0;
        for (int i = 0; i < 256; i++) mem[i] = 16'hFFFF;

        // Reset values and idling without start
        #1;
        check("reset_outs", outs(), 32'd0);
        tick();
        tick();
        rst_n = 1'b1;
        tick();
        tick();
        tick();
        check("idle_no_start", outs(), 32'd0);

        // Basic sequence: write, delay, write, end
        load_basic();
        sccb_ready = 1'b1;
        clear_log();
        pulse_start();
        c0 = cyc;
        check("busy_after_start", 32'(busy), 32'd1);
        tick();
        check("valid_low_decode", 32'(sccb_valid), 32'd0);
        tick();
        check("first_write", {23'd0, sccb_valid, sccb_reg, sccb_data}, {23'd0, 1'b1, 16'h1280});
        wait_done(100);
        check("basic_end", {22'd0, rom_addr, busy, done}, {22'd0, 8'd3, 1'b0, 1'b1});
        check("basic_count", 32'(xr_q.size()), 32'd2);
        check("basic_w0", {xr_q[0], xd_q[0]}, 32'h1280);
        check("basic_w1", {xr_q[1], xd_q[1]}, 32'h1214);
        check("basic_lat", 32'(xc_q[0] - c0), 32'd3);
        check("delay_gap", 32'(xc_q[1] - xc_q[0]), 32'd13);

        // Backpressure: request held for 5 stalled clocks, then one transfer
        for (int i = 0; i < 256; i++) mem[i] = 16'hFFFF;
        mem[0] = 16'h3A04;
        sccb_ready = 1'b0;
        clear_log();
        pulse_start();
        check("restart_clears_done", 32'(done), 32'd0);
        wait_valid(10);
        for (int i = 0; i < 5; i++) begin
            tick();
            check("stall_hold", {23'd0, sccb_valid, sccb_reg, sccb_data}, {23'd0, 1'b1, 16'h3A04});
        end
        check("stall_no_xfer", 32'(xr_q.size()), 32'd0);
        sccb_ready = 1'b1;
        tick();
        check("stall_one_xfer", 32'(xr_q.size()), 32'd1);
        check("stall_valid_low", 32'(sccb_valid), 32'd0);
        wait_done(20);
        check("stall_count", 32'(xr_q.size()), 32'd1);
        check("stall_w0", {xr_q[0], xd_q[0]}, 32'h3A04);

        // Start during DELAY is ignored; start in DONE replays the sequence
        load_basic();
        clear_log();
        pulse_start();
        begin
            int n;
            n = 0;
            while (xr_q.size() < 1 && n < 20) begin
                tick();
                n++;
            end
        end
        tick();
        tick();
        tick();
        pulse_start();
        check("busy_in_delay", 32'(busy), 32'd1);
        wait_done(100);
        check("ignored_count", 32'(xr_q.size()), 32'd2);
        check("ignored_gap", 32'(xc_q[1] - xc_q[0]), 32'd13);
        pulse_start();
        check("replay_done_clr", {30'd0, busy, done}, {30'd0, 1'b1, 1'b0});
        wait_done(100);
        check("replay_count", 32'(xr_q.size()), 32'd4);
        check("replay_w0", {xr_q[2], xd_q[2]}, 32'h1280);
        check("replay_w1", {xr_q[3], xd_q[3]}, 32'h1214);

        // No end marker: reset mid-run first, then a full 256-entry pass
        for (int i = 0; i < 256; i++) mem[i] = 16'h0101;
        clear_log();
        pulse_start();
        begin
            int n;
            n = 0;
            while (xr_q.size() < 10 && n < 100) begin
                tick();
                n++;
            end
        end
        check("addr_advanced", 32'(rom_addr != 8'd0), 32'd1);
        #2 rst_n = 1'b0;
        #1 check("midrun_reset", outs(), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        tick();
        tick();
        check("post_reset_idle", outs(), 32'd0);
        clear_log();
        pulse_start();
        wait_done(1000);
        dcyc = cyc;
        check("full_count", 32'(xr_q.size()), 32'd256);
        check("full_end", {22'd0, rom_addr, busy, done}, {22'd0, 8'hFF, 1'b0, 1'b1});
        check("full_last", {xr_q[255], xd_q[255]}, 32'h0101);
        check("full_done_edge", 32'(dcyc - xc_q[255]), 32'd0);

        // Reset during a stalled SEND, then the first write is entry 0
        for (int i = 0; i < 256; i++) mem[i] = 16'hFFFF;
        mem[0] = 16'h5511;
        mem[1] = 16'h6622;
        sccb_ready = 1'b0;
        clear_log();
        pulse_start();
        wait_valid(10);
        tick();
        tick();
        #2 rst_n = 1'b0;
        #1 check("send_reset", outs(), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        sccb_ready = 1'b1;
        tick();
        tick();
        check("send_reset_idle", {30'd0, busy, sccb_valid}, 32'd0);
        pulse_start();
        wait_done(50);
        check("after_rst_count", 32'(xr_q.size()), 32'd2);
        check("after_rst_w0", {xr_q[0], xd_q[0]}, 32'h5511);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
